// File: rtl/alu_rs_scheduler.sv
// Reservation station for the shared integer ALU: tracks operand tags, wakes
// operands from the CDB, issues one ready entry per cycle and broadcasts results.
module alu_rs_scheduler #(
    parameter int RS_WIDTH  = 2,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 disp_valid,
    input  logic [3:0]           disp_op,
    input  logic [31:0]          disp_vj,
    input  logic [31:0]          disp_vk,
    input  logic                 disp_qj_busy,
    input  logic                 disp_qk_busy,
    input  logic [ROB_WIDTH-1:0] disp_qj,
    input  logic [ROB_WIDTH-1:0] disp_qk,
    input  logic [ROB_WIDTH-1:0] disp_rob,
    output logic                 rs_full,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_rob,
    input  logic [31:0]          cdb_value,
    output logic                 alu_cal,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_op,
    output logic [RS_WIDTH-1:0]  alu_index,
    input  logic                 alu_done,
    input  logic [RS_WIDTH-1:0]  alu_done_idx,
    input  logic [31:0]          alu_result,
    output logic                 out_valid,
    output logic [ROB_WIDTH-1:0] out_rob,
    output logic [31:0]          out_value
);
    localparam int unsigned RS_SIZE = 1 << RS_WIDTH;

    typedef enum logic [1:0] {ENT_FREE, ENT_WAIT, ENT_READY, ENT_ISSUED} ent_state_t;

    ent_state_t           state_q   [RS_SIZE];
    ent_state_t           state_d   [RS_SIZE];
    logic [3:0]           op_q      [RS_SIZE];
    logic [3:0]           op_d      [RS_SIZE];
    logic [31:0]          vj_q      [RS_SIZE];
    logic [31:0]          vj_d      [RS_SIZE];
    logic [31:0]          vk_q      [RS_SIZE];
    logic [31:0]          vk_d      [RS_SIZE];
    logic                 qj_busy_q [RS_SIZE];
    logic                 qj_busy_d [RS_SIZE];
    logic                 qk_busy_q [RS_SIZE];
    logic                 qk_busy_d [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_q      [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_d      [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_q      [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_d      [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_q     [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_d     [RS_SIZE];

    logic                 rs_full_d, alu_cal_d, out_valid_d;
    logic [31:0]          alu_a_d, alu_b_d, out_value_d;
    logic [3:0]           alu_op_d;
    logic [RS_WIDTH-1:0]  alu_index_d, free_idx, ready_idx;
    logic [ROB_WIDTH-1:0] out_rob_d;
    logic                 free_found, ready_found, full_next;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        qj_busy_d   = qj_busy_q;
        qk_busy_d   = qk_busy_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        rob_d       = rob_q;
        rs_full_d   = rs_full;
        alu_cal_d   = 1'b0;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_op_d    = alu_op;
        alu_index_d = alu_index;
        out_valid_d = 1'b0;
        out_rob_d   = out_rob;
        out_value_d = out_value;
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        full_next   = 1'b1;

        // Dispatch and issue both select from the state at the edge, so an entry
        // freed or readied this cycle is only visible to them next cycle.
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!free_found && state_q[i] == ENT_FREE) begin
                free_found = 1'b1;
                free_idx   = RS_WIDTH'(i);
            end
            if (!ready_found && state_q[i] == ENT_READY) begin
                ready_found = 1'b1;
                ready_idx   = RS_WIDTH'(i);
            end
        end

        if (clear) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) state_d[i] = ENT_FREE;
            rs_full_d = 1'b0;
        end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (state_q[i] == ENT_WAIT) begin
                    if (cdb_valid && qj_busy_q[i] && qj_q[i] == cdb_rob) begin
                        vj_d[i]      = cdb_value;
                        qj_busy_d[i] = 1'b0;
                    end
                    if (cdb_valid && qk_busy_q[i] && qk_q[i] == cdb_rob) begin
                        vk_d[i]      = cdb_value;
                        qk_busy_d[i] = 1'b0;
                    end
                    if (!qj_busy_d[i] && !qk_busy_d[i]) state_d[i] = ENT_READY;
                end
            end

            if (ready_found) begin
                state_d[ready_idx] = ENT_ISSUED;
                alu_cal_d          = 1'b1;
                alu_a_d            = vj_q[ready_idx];
                alu_b_d            = vk_q[ready_idx];
                alu_op_d           = op_q[ready_idx];
                alu_index_d        = ready_idx;
            end

            if (alu_done && state_q[alu_done_idx] == ENT_ISSUED) begin
                state_d[alu_done_idx] = ENT_FREE;
                out_valid_d           = 1'b1;
                out_rob_d             = rob_q[alu_done_idx];
                out_value_d           = alu_result;
            end

            if (disp_valid && !rs_full && free_found) begin
                op_d[free_idx]      = disp_op;
                rob_d[free_idx]     = disp_rob;
                qj_d[free_idx]      = disp_qj;
                qk_d[free_idx]      = disp_qk;
                vj_d[free_idx]      = disp_vj;
                vk_d[free_idx]      = disp_vk;
                qj_busy_d[free_idx] = disp_qj_busy;
                qk_busy_d[free_idx] = disp_qk_busy;
                if (disp_qj_busy && cdb_valid && disp_qj == cdb_rob) begin
                    vj_d[free_idx]      = cdb_value;
                    qj_busy_d[free_idx] = 1'b0;
                end
                if (disp_qk_busy && cdb_valid && disp_qk == cdb_rob) begin
                    vk_d[free_idx]      = cdb_value;
                    qk_busy_d[free_idx] = 1'b0;
                end
                state_d[free_idx] = (qj_busy_d[free_idx] || qk_busy_d[free_idx]) ? ENT_WAIT : ENT_READY;
            end

            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (state_d[i] == ENT_FREE) full_next = 1'b0;
            end
            rs_full_d = full_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                state_q[i]   <= ENT_FREE;
                op_q[i]      <= '0;
                vj_q[i]      <= '0;
                vk_q[i]      <= '0;
                qj_busy_q[i] <= 1'b0;
                qk_busy_q[i] <= 1'b0;
                qj_q[i]      <= '0;
                qk_q[i]      <= '0;
                rob_q[i]     <= '0;
            end
            rs_full   <= 1'b0;
            alu_cal   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_index <= '0;
            out_valid <= 1'b0;
            out_rob   <= '0;
            out_value <= '0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            op_q      <= op_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            qj_busy_q <= qj_busy_d;
            qk_busy_q <= qk_busy_d;
            qj_q      <= qj_d;
            qk_q      <= qk_d;
            rob_q     <= rob_d;
            rs_full   <= rs_full_d;
            alu_cal   <= alu_cal_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_op    <= alu_op_d;
            alu_index <= alu_index_d;
            out_valid <= out_valid_d;
            out_rob   <= out_rob_d;
            out_value <= out_value_d;
        end
    end
endmodule
